// File: rtl/util_axis_1553_string_decoder_serial.sv
// Byte-serial ASCII 1553 line decoder: "TTTT;Dd;Pp;Ii;Hx<hex>\r\n" -> one AXIS word plus tuser descriptor.
// Optional err/err_count outputs are enabled with `define UTIL_AXIS_1553_STRING_DECODER_ERR_EN.
module util_axis_1553_string_decoder_serial #(
    parameter int HEX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int STRICT_CRLF    = 1
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [4*HEX_DIGITS-1:0]   m_axis_tdata,
    output logic [7:0]                m_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
    ,
    output logic                      err,
    output logic [15:0]               err_count
`endif
);

    localparam int W = 4 * HEX_DIGITS;
    localparam logic [7:0] CH_CR = 8'h0d;
    localparam logic [7:0] CH_LF = 8'h0a;

    typedef enum logic [4:0] {
        ST_TYPE, ST_SEMI_D, ST_D_KEY, ST_D_VAL, ST_SEMI_P, ST_P_KEY, ST_P_VAL,
        ST_SEMI_I, ST_I_KEY, ST_I_VAL, ST_SEMI_H, ST_H_KEY, ST_X_KEY, ST_HEX,
        ST_CR, ST_LF, ST_FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     tm_q, tm_d;
    logic [2:0]     typ_q, typ_d;
    logic [2:0]     dly_q, dly_d;
    logic           par_q, par_d;
    logic           ifl_q, ifl_d;
    logic [W-1:0]   hex_q, hex_d;
    logic           beat;
    logic           bad;
    logic           line_done;
    logic           line_idle;
    logic           at_term;
    logic           timeout_hit;
    logic [2:0]     tmatch;
    logic [4:0]     nib;

    // Candidate-match step for the type field; bit order {CMDS, STAT, DATA} equals the type code.
    function automatic logic [2:0] type_step(input logic [2:0] i, input logic [7:0] c);
        logic [2:0] m;
        m = '0;
        case (i)
            3'd0:    m = {c == "C", c == "S", c == "D"};
            3'd1:    m = {c == "M", c == "T", c == "A"};
            3'd2:    m = {c == "D", c == "A", c == "T"};
            3'd3:    m = {c == "S", c == "T", c == "A"};
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        r = '0;
        if (c >= "0" && c <= "9") begin
            r = {1'b1, c[3:0]};
        end else if ((c >= "A" && c <= "F") || (c >= "a" && c <= "f")) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

    // Output-side combinational controls
    always_comb begin
        at_term       = (state_q == ST_LF) || (STRICT_CRLF == 0 && state_q == ST_CR);
        s_axis_tready = rst | ~(at_term & m_axis_tvalid & ~m_axis_tready);
        beat          = s_axis_tvalid & s_axis_tready;
        line_idle     = (state_q == ST_TYPE) && (idx_q == '0);
    end

    // State register
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= ST_TYPE;
            idx_q   <= '0;
            tm_q    <= '1;
            typ_q   <= '0;
            dly_q   <= '0;
            par_q   <= 1'b0;
            ifl_q   <= 1'b0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tm_q    <= tm_d;
            typ_q   <= typ_d;
            dly_q   <= dly_d;
            par_q   <= par_d;
            ifl_q   <= ifl_d;
            hex_q   <= hex_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tm_d      = tm_q;
        typ_d     = typ_q;
        dly_d     = dly_q;
        par_d     = par_q;
        ifl_d     = ifl_q;
        hex_d     = hex_q;
        bad       = 1'b0;
        line_done = 1'b0;
        tmatch    = type_step(idx_q, s_axis_tdata) & tm_q;
        nib       = hex_nib(s_axis_tdata);

        if (timeout_hit) begin
            state_d = ST_TYPE;
            idx_d   = '0;
            tm_d    = '1;
        end else if (beat) begin
            case (state_q)
                ST_TYPE: begin
                    if (tmatch == '0) begin
                        bad = 1'b1;
                    end else if (idx_q == 3'd3) begin
                        typ_d   = tmatch;
                        idx_d   = '0;
                        tm_d    = '1;
                        state_d = ST_SEMI_D;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tm_d  = tmatch;
                    end
                end
                ST_SEMI_D: if (s_axis_tdata == ";") state_d = ST_D_KEY; else bad = 1'b1;
                ST_D_KEY:  if (s_axis_tdata == "D") state_d = ST_D_VAL; else bad = 1'b1;
                ST_D_VAL: begin
                    if (s_axis_tdata >= "0" && s_axis_tdata <= "7") begin
                        dly_d   = s_axis_tdata[2:0];
                        state_d = ST_SEMI_P;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_SEMI_P: if (s_axis_tdata == ";") state_d = ST_P_KEY; else bad = 1'b1;
                ST_P_KEY:  if (s_axis_tdata == "P") state_d = ST_P_VAL; else bad = 1'b1;
                ST_P_VAL: begin
                    if (s_axis_tdata == "0" || s_axis_tdata == "1") begin
                        par_d   = s_axis_tdata[0];
                        state_d = ST_SEMI_I;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_SEMI_I: if (s_axis_tdata == ";") state_d = ST_I_KEY; else bad = 1'b1;
                ST_I_KEY:  if (s_axis_tdata == "I") state_d = ST_I_VAL; else bad = 1'b1;
                ST_I_VAL: begin
                    if (s_axis_tdata == "0" || s_axis_tdata == "1") begin
                        ifl_d   = s_axis_tdata[0];
                        state_d = ST_SEMI_H;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_SEMI_H: if (s_axis_tdata == ";") state_d = ST_H_KEY; else bad = 1'b1;
                ST_H_KEY:  if (s_axis_tdata == "H") state_d = ST_X_KEY; else bad = 1'b1;
                ST_X_KEY:  if (s_axis_tdata == "x") state_d = ST_HEX;   else bad = 1'b1;
                ST_HEX: begin
                    if (nib[4]) begin
                        hex_d = (hex_q << 4) | W'(nib[3:0]);
                        if (idx_q == 3'(HEX_DIGITS - 1)) begin
                            idx_d   = '0;
                            state_d = ST_CR;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_CR: begin
                    if (s_axis_tdata == CH_CR) begin
                        state_d = ST_LF;
                    end else if (STRICT_CRLF == 0 && s_axis_tdata == CH_LF) begin
                        line_done = 1'b1;
                        state_d   = ST_TYPE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_LF: begin
                    if (s_axis_tdata == CH_LF) begin
                        line_done = 1'b1;
                        state_d   = ST_TYPE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                ST_FLUSH: if (s_axis_tdata == CH_LF) state_d = ST_TYPE;
                default:  state_d = ST_TYPE;
            endcase

            // A bad character that is itself the LF already ends the line, so skip FLUSH.
            if (bad) begin
                state_d = (s_axis_tdata == CH_LF) ? ST_TYPE : ST_FLUSH;
                idx_d   = '0;
                tm_d    = '1;
            end
        end
    end

    // Timeout counts cycles without an accepted beat, excluding our own backpressure stalls.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [TW-1:0] to_cnt;
            logic          to_last;

            assign to_last     = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
            assign timeout_hit = !beat && !line_idle && s_axis_tready && to_last;

            always_ff @(posedge aclk) begin
                if (rst || beat || line_idle || !s_axis_tready || to_last) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Output register: loads on the terminating LF, holds until drained.
    always_ff @(posedge aclk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (line_done) begin
            m_axis_tdata  <= hex_q;
            m_axis_tuser  <= {typ_q, ifl_q, dly_q, par_q};
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
    logic err_event;
    assign err_event = bad | timeout_hit;

    always_ff @(posedge aclk) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= err_event;
            if (err_event && err_count != '1) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_util_axis_1553_string_decoder_serial.sv
// Directed bench for util_axis_1553_string_decoder_serial across four parameter sets.
module tb_util_axis_1553_string_decoder_serial;

    logic        tb_data_clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata  [4];
    logic        s_tvalid [4];
    logic        s_tready [4];
    logic        m_tready [4];
    logic        m_tvalid [4];
    logic [7:0]  m_tuser  [4];
    logic [31:0] m_tdata  [4];
    logic [15:0] d0, d1;
    logic [31:0] d2, d3;
    logic [39:0] q0[$], q1[$], q2[$], q3[$];
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
    logic        err_w [4];
    logic [15:0] errc  [4];
    int          nerr  [4] = '{0, 0, 0, 0};
    always @(posedge tb_data_clk) begin
        for (int i = 0; i < 4; i++) if (err_w[i]) nerr[i]++;
    end
`endif

    always #5 tb_data_clk = ~tb_data_clk;

    assign m_tdata[0] = {16'h0, d0};
    assign m_tdata[1] = {16'h0, d1};
    assign m_tdata[2] = d2;
    assign m_tdata[3] = d3;

    // u0: defaults; u1: timeout 20; u2: 8 digits, bare LF allowed; u3: 8 digits, strict CRLF
    util_axis_1553_string_decoder_serial #(.HEX_DIGITS(4), .TIMEOUT_CYCLES(0), .STRICT_CRLF(1)) u0 (
        .aclk(tb_data_clk), .rst(rst),
        .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(d0), .m_axis_tuser(m_tuser[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tready(m_tready[0])
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        , .err(err_w[0]), .err_count(errc[0])
`endif
    );

    util_axis_1553_string_decoder_serial #(.HEX_DIGITS(4), .TIMEOUT_CYCLES(20), .STRICT_CRLF(1)) u1 (
        .aclk(tb_data_clk), .rst(rst),
        .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(d1), .m_axis_tuser(m_tuser[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tready(m_tready[1])
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        , .err(err_w[1]), .err_count(errc[1])
`endif
    );

    util_axis_1553_string_decoder_serial #(.HEX_DIGITS(8), .TIMEOUT_CYCLES(0), .STRICT_CRLF(0)) u2 (
        .aclk(tb_data_clk), .rst(rst),
        .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
        .m_axis_tdata(d2), .m_axis_tuser(m_tuser[2]), .m_axis_tvalid(m_tvalid[2]),
        .m_axis_tready(m_tready[2])
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        , .err(err_w[2]), .err_count(errc[2])
`endif
    );

    util_axis_1553_string_decoder_serial #(.HEX_DIGITS(8), .TIMEOUT_CYCLES(0), .STRICT_CRLF(1)) u3 (
        .aclk(tb_data_clk), .rst(rst),
        .s_axis_tdata(s_tdata[3]), .s_axis_tvalid(s_tvalid[3]), .s_axis_tready(s_tready[3]),
        .m_axis_tdata(d3), .m_axis_tuser(m_tuser[3]), .m_axis_tvalid(m_tvalid[3]),
        .m_axis_tready(m_tready[3])
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        , .err(err_w[3]), .err_count(errc[3])
`endif
    );

    // Output capture on real handshakes
    always @(posedge tb_data_clk) begin
        if (m_tvalid[0] && m_tready[0]) q0.push_back({m_tuser[0], m_tdata[0]});
        if (m_tvalid[1] && m_tready[1]) q1.push_back({m_tuser[1], m_tdata[1]});
        if (m_tvalid[2] && m_tready[2]) q2.push_back({m_tuser[2], m_tdata[2]});
        if (m_tvalid[3] && m_tready[3]) q3.push_back({m_tuser[3], m_tdata[3]});
    end

    task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic qpop(input int k, output logic [39:0] v);
        v = '0;
        case (k)
            0:       if (q0.size() > 0) v = q0.pop_front();
            1:       if (q1.size() > 0) v = q1.pop_front();
            2:       if (q2.size() > 0) v = q2.pop_front();
            default: if (q3.size() > 0) v = q3.pop_front();
        endcase
    endtask

    task automatic expect_word(input int k, input string tag, input logic [7:0] u, input logic [31:0] d);
        logic [39:0] v;
        qpop(k, v);
        check_val(tag, v, {u, d});
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_byte(input int k, input logic [7:0] c);
        int n;
        n = 0;
        s_tdata[k]  = c;
        s_tvalid[k] = 1'b1;
        while (!s_tready[k] && n < 50) begin
            @(negedge tb_data_clk);
            n++;
        end
        if (!s_tready[k]) begin
            check_val("ready_wait", 40'(s_tready[k]), 40'd1);
        end else begin
            @(posedge tb_data_clk);
            @(negedge tb_data_clk);
        end
        s_tvalid[k] = 1'b0;
    endtask

    task automatic send_str(input int k, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(k, s[i]);
    endtask

    task automatic send_line(input int k, input string s);
        send_str(k, s);
        send_byte(k, 8'h0d);
        send_byte(k, 8'h0a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            s_tdata[i]  = '0;
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge tb_data_clk);
        check_val("rst_tvalid", 40'(m_tvalid[0]), 40'd0);
        check_val("rst_tdata",  40'(m_tdata[0]),  40'd0);
        check_val("rst_tuser",  40'(m_tuser[0]),  40'd0);
        check_val("rst_sready", 40'(s_tready[0]), 40'd1);
        rst = 1'b0;
        @(negedge tb_data_clk);

        // Basic line, latency 1 after LF
        send_str(0, "DATA;D1;P1;I0;HxA5F0");
        send_byte(0, 8'h0d);
        check_val("t1_pre_lf",  40'(m_tvalid[0]), 40'd0);
        send_byte(0, 8'h0a);
        check_val("t1_valid",   40'(m_tvalid[0]), 40'd1);
        check_val("t1_tdata",   40'(m_tdata[0]),  40'h0000A5F0);
        check_val("t1_tuser",   40'(m_tuser[0]),  40'h23);
        @(negedge tb_data_clk);
        check_val("t1_one_beat", 40'(m_tvalid[0]), 40'd0);
        check_val("t1_cnt",     40'(qsize(0)),    40'd1);
        expect_word(0, "t1_word", 8'h23, 32'h0000A5F0);

        // Backpressure: hold first word, block at second LF, drain + reload together
        m_tready[0] = 1'b0;
        send_line(0, "CMDS;D7;P0;I1;Hx00ff");
        send_str(0, "STAT;D0;P1;I1;Hx1234");
        send_byte(0, 8'h0d);
        s_tdata[0]  = 8'h0a;
        s_tvalid[0] = 1'b1;
        repeat (4) @(negedge tb_data_clk);
        check_val("t2_blocked", 40'(s_tready[0]), 40'd0);
        check_val("t2_held",    40'(m_tdata[0]),  40'h000000FF);
        check_val("t2_held_u",  40'(m_tuser[0]),  40'h9E);
        m_tready[0] = 1'b1;
        @(negedge tb_data_clk);
        s_tvalid[0] = 1'b0;
        check_val("t2_no_bubble", 40'(m_tvalid[0]), 40'd1);
        check_val("t2_reload",  40'(m_tdata[0]),  40'h00001234);
        @(negedge tb_data_clk);
        check_val("t2_cnt",     40'(qsize(0)),    40'd2);
        expect_word(0, "t2_word0", 8'h9E, 32'h000000FF);
        expect_word(0, "t2_word1", 8'h51, 32'h00001234);

        // Malformed delay digit, then a good line
        send_line(0, "DATA;D9;P1;I0;HxA5F0");
        repeat (2) @(negedge tb_data_clk);
        check_val("t3_no_out",  40'(qsize(0)),    40'd0);
        send_line(0, "STAT;D5;P0;I1;Hxbeef");
        @(negedge tb_data_clk);
        check_val("t3_cnt",     40'(qsize(0)),    40'd1);
        expect_word(0, "t3_word", 8'h5A, 32'h0000BEEF);
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        check_val("t3_err_count", 40'(errc[0]), 40'd1);
        check_val("t3_err_pulses", 40'(nerr[0]), 40'd1);
`endif

        // Timeout: 19 idle cycles survive, 20 and 25 abort
        send_str(1, "DATA;D1");
        repeat (19) @(negedge tb_data_clk);
        send_line(1, ";P1;I0;Hx0001");
        @(negedge tb_data_clk);
        check_val("to19_cnt", 40'(qsize(1)), 40'd1);
        expect_word(1, "to19_word", 8'h23, 32'h00000001);
        send_str(1, "DATA;D1");
        repeat (20) @(negedge tb_data_clk);
        send_line(1, "CMDS;D2;P1;I0;Hx4321");
        @(negedge tb_data_clk);
        check_val("to20_cnt", 40'(qsize(1)), 40'd1);
        expect_word(1, "to20_word", 8'h85, 32'h00004321);
        send_str(1, "DATA;D1");
        repeat (25) @(negedge tb_data_clk);
        send_line(1, "STAT;D6;P0;I0;Hx0a0B");
        @(negedge tb_data_clk);
        check_val("to25_cnt", 40'(qsize(1)), 40'd1);
        expect_word(1, "to25_word", 8'h4C, 32'h00000A0B);
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        check_val("to_err_count", 40'(errc[1]), 40'd2);
`endif

        // Bare LF with STRICT_CRLF=0 and 8 digits
        send_str(2, "DATA;D2;P0;I0;HxDEADBEEF");
        send_byte(2, 8'h0a);
        check_val("lf_valid", 40'(m_tvalid[2]), 40'd1);
        send_line(2, "CMDS;D0;P1;I1;Hx00000001");
        @(negedge tb_data_clk);
        check_val("lf_cnt", 40'(qsize(2)), 40'd2);
        expect_word(2, "lf_word0", 8'h24, 32'hDEADBEEF);
        expect_word(2, "lf_word1", 8'h91, 32'h00000001);

        // Same bare-LF line with STRICT_CRLF=1 is rejected; next line survives
        send_str(3, "DATA;D2;P0;I0;HxDEADBEEF");
        send_byte(3, 8'h0a);
        repeat (2) @(negedge tb_data_clk);
        check_val("strict_no_out", 40'(qsize(3)), 40'd0);
        send_line(3, "DATA;D2;P0;I0;HxDEADBEEF");
        @(negedge tb_data_clk);
        check_val("strict_cnt", 40'(qsize(3)), 40'd1);
        expect_word(3, "strict_word", 8'h24, 32'hDEADBEEF);
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        check_val("strict_err_count", 40'(errc[3]), 40'd1);
`endif

        // Reset with a held word and a partial line
        m_tready[0] = 1'b0;
        send_line(0, "CMDS;D1;P0;I0;Hx7777");
        send_str(0, "STAT;D3");
        check_val("rst2_held", 40'(m_tvalid[0]), 40'd1);
        rst = 1'b1;
        @(negedge tb_data_clk);
        for (int i = 0; i < 3; i++) begin
            m_tready[0] = 1'($urandom_range(0, 1));
            @(negedge tb_data_clk);
            check_val("rst2_tvalid", 40'(m_tvalid[0]), 40'd0);
            check_val("rst2_tdata",  40'(m_tdata[0]),  40'd0);
            check_val("rst2_tuser",  40'(m_tuser[0]),  40'd0);
            check_val("rst2_sready", 40'(s_tready[0]), 40'd1);
        end
`ifdef UTIL_AXIS_1553_STRING_DECODER_ERR_EN
        check_val("rst2_err_count", 40'(errc[0]), 40'd0);
`endif
        rst = 1'b0;
        m_tready[0] = 1'b1;
        @(negedge tb_data_clk);
        send_line(0, "DATA;D4;P0;I0;Hx0F1e");
        @(negedge tb_data_clk);
        check_val("rst2_cnt", 40'(qsize(0)), 40'd1);
        expect_word(0, "rst2_word", 8'h28, 32'h00000F1E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
